muldiv_issue_ctrl: RTL and testbench
====================================

MULDIV_ISSUE_CTRL -- requirements
Module: muldiv_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 ex_valid  input  1  execute-stage instruction valid.
REQ-003 ex_alucode  input  6  ALU_* encoding.
REQ-004 ex_op1 / ex_op2  input  32  source operands.
REQ-005 ex_rd  input  5  destination register.
REQ-006 ex_reg_we  input  1  instruction writes rd.
REQ-007 flush  input  1  pipeline flush; abort the in-flight op.
REQ-008 stall  output  1  hold all upstream stages.
REQ-009 alu_start  output  1  drives multiclockalu.is_multiclock_input.
REQ-010 alu_code  output  6  held opcode; alu_op1 / alu_op2  output  32  held operands.
REQ-011 alu_result  input  32  multiclockalu result; alu_done  input  1  multiclockalu done.
REQ-012 wb_valid  output  1  write-back strobe; wb_rd  output  5; wb_we  output  1; wb_data  output  32.
REQ-013 busy_cycles  output  8  saturating count of BUSY cycles for the last op.

Function
REQ-014 The M-op set SHALL be ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU; all other alucodes SHALL be ignored, with no stall.
REQ-015 The state machine SHALL have the states IDLE, BUSY, WB and DRAIN.
REQ-016 Accept condition: state IDLE & ex_valid & M-op & !flush.
- On accept, stall SHALL be 1 combinationally in that cycle.
- At the next edge the block SHALL latch alucode, op1, op2, rd and reg_we, and enter BUSY.
REQ-017 alu_start SHALL be a single-cycle registered pulse in the first BUSY cycle; alu_code, alu_op1 and alu_op2 SHALL stay stable from that cycle until the block returns to IDLE.
REQ-018 alu_done SHALL be ignored in the first BUSY cycle, so a stale done is never taken; from the second BUSY cycle, alu_done=1 SHALL capture alu_result and move BUSY->WB.
REQ-019 WB SHALL last exactly one cycle.
- wb_valid=1, with wb_data, wb_rd and wb_we taken from the latched values.
- stall=0 in this cycle.
- ex_* inputs SHALL NOT be accepted in this cycle.
- Next state: IDLE.
REQ-020 stall SHALL be 1 throughout BUSY.
REQ-021 flush in BUSY SHALL move the block to DRAIN with no WB.
- DRAIN SHALL wait for alu_done, discard the result, then go to IDLE.
- stall=1 in DRAIN only while ex_valid & M-op.
REQ-022 flush SHALL take priority over alu_done in the same cycle (BUSY->DRAIN).
- If done and flush coincide in a done-eligible BUSY cycle, the op SHALL be discarded and the block SHALL go directly to IDLE.
REQ-023 flush in IDLE SHALL block acceptance that cycle; flush in WB SHALL NOT suppress the write-back.
REQ-024 busy_cycles SHALL clear on accept, increment on each BUSY cycle, saturate at 255, and hold after WB.
REQ-025 Every output not named as active in a given state SHALL be 0 (busy_cycles excepted, per REQ-024).

Reset
REQ-026 While rst_n=0 the block SHALL be in IDLE.
- Outputs SHALL be 0: stall, alu_start, alu_code, alu_op1, alu_op2, wb_valid, wb_rd, wb_we, wb_data, busy_cycles.
REQ-027 Reset asserted mid-BUSY or mid-DRAIN SHALL abandon the op with no write-back.
- The first post-reset accept SHALL still apply the first-cycle done mask of REQ-018.

Configuration
REQ-028 When MULDIV_DIVZERO_FAST_EN is defined, an accepted DIV/DIVU/REM/REMU with op2==0 SHALL skip alu_start and go IDLE->WB directly.
- DIV/DIVU: wb_data=0xFFFFFFFF.
- REM/REMU: wb_data=op1.
- busy_cycles=0.
REQ-029 When MULDIV_DIVZERO_FAST_EN is undefined, divide-by-zero SHALL be launched to the ALU like any other op.

Verification
REQ-030 MUL, op1=0x00003141, op2=0x00005926, rd=5 -> one alu_start pulse; stall high until WB; wb_valid once with wb_data=0x1126E8A6, wb_rd=5.
REQ-031 MULH, op1=-4, op2=7; alu_done held high from the previous op -> done ignored in the first BUSY cycle; wb_data=0xFFFFFFFF only after a fresh done.
REQ-032 DIV 0x27182818/0x1234 with flush pulsed in the 3rd BUSY cycle -> no wb_valid; a following MUL is accepted only after done is seen in DRAIN.
REQ-033 DIV, op1=10, op2=0, macro defined -> alu_start never 1; wb_valid in the 2nd cycle with wb_data=0xFFFFFFFF. Macro undefined -> op launched to the ALU.
REQ-034 rst_n low in the 4th BUSY cycle -> all outputs 0 immediately; no wb_valid follows after release.
REQ-035 ADD alucode with ex_valid=1 -> stall=0, alu_start=0, wb_valid=0.

Source files
------------

// File: rtl/muldiv_issue_ctrl.sv
// Issue/hold controller that sequences M-extension ops onto a multi-cycle ALU and returns the result for write-back.
// Optional build macro: MULDIV_DIVZERO_FAST_EN (divide-by-zero retires without launching the ALU).
module muldiv_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  ex_alucode,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        flush,
    output logic        stall,
    output logic        alu_start,
    output logic [5:0]  alu_code,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic [7:0]  busy_cycles
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CODE_W-1:0] ALU_MUL    = CODE_W'(32);
    localparam logic [CODE_W-1:0] ALU_MULH   = CODE_W'(33);
    localparam logic [CODE_W-1:0] ALU_MULHSU = CODE_W'(34);
    localparam logic [CODE_W-1:0] ALU_MULHU  = CODE_W'(35);
    localparam logic [CODE_W-1:0] ALU_DIV    = CODE_W'(36);
    localparam logic [CODE_W-1:0] ALU_DIVU   = CODE_W'(37);
    localparam logic [CODE_W-1:0] ALU_REM    = CODE_W'(38);
    localparam logic [CODE_W-1:0] ALU_REMU   = CODE_W'(39);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        WB    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              is_mop;
    logic              accept;
    logic              done_ok;
    logic              fast;
    logic [XLEN-1:0]   fast_data;
    logic [REG_W-1:0]  rd_q;
    logic              we_q;

    // M-op decode
    always_comb begin
        is_mop = 1'b0;
        case (ex_alucode)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_mop = 1'b1;
            default:                              is_mop = 1'b0;
        endcase
    end

`ifdef MULDIV_DIVZERO_FAST_EN
    // Divide-by-zero has an architecturally fixed result, so it can retire without the ALU
    always_comb begin
        fast      = 1'b0;
        fast_data = '0;
        case (ex_alucode)
            ALU_DIV, ALU_DIVU: begin
                fast      = (ex_op2 == '0);
                fast_data = '1;
            end
            ALU_REM, ALU_REMU: begin
                fast      = (ex_op2 == '0);
                fast_data = ex_op1;
            end
            default: ;
        endcase
    end
`else
    assign fast      = 1'b0;
    assign fast_data = '0;
`endif

    assign accept  = (state == IDLE) && ex_valid && is_mop && !flush;
    // alu_start marks the first BUSY cycle, which masks any done left over from a previous op
    assign done_ok = (state == BUSY) && !alu_start && alu_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_d = fast ? WB : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)        state_d = done_ok ? IDLE : DRAIN;
                else if (done_ok) state_d = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall = ex_valid && is_mop;
                if (alu_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall = stall && rst_n;
    end

    // Launch registers, write-back registers and cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_start   <= 1'b0;
            alu_code    <= '0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_we       <= 1'b0;
            wb_data     <= '0;
            busy_cycles <= '0;
        end else begin
            alu_start <= (state == IDLE) && (state_d == BUSY);

            if (accept && !fast) begin
                alu_code <= ex_alucode;
                alu_op1  <= ex_op1;
                alu_op2  <= ex_op2;
            end else if (state_d == IDLE) begin
                alu_code <= '0;
                alu_op1  <= '0;
                alu_op2  <= '0;
            end

            if (accept) begin
                rd_q <= ex_rd;
                we_q <= ex_reg_we;
            end

            wb_valid <= (state_d == WB);
            if (state_d == WB) begin
                wb_rd   <= (state == IDLE) ? ex_rd     : rd_q;
                wb_we   <= (state == IDLE) ? ex_reg_we : we_q;
                wb_data <= (state == IDLE) ? fast_data : alu_result;
            end else begin
                wb_rd   <= '0;
                wb_we   <= 1'b0;
                wb_data <= '0;
            end

            if (accept)
                busy_cycles <= '0;
            else if ((state == BUSY) && (busy_cycles != '1))
                busy_cycles <= busy_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed testbench for muldiv_issue_ctrl; the bench plays the role of the multi-cycle ALU.
module tb_muldiv_issue_ctrl;

    localparam logic [5:0] ALU_ADD   = 6'd1;
    localparam logic [5:0] ALU_MUL   = 6'd32;
    localparam logic [5:0] ALU_MULH  = 6'd33;
    localparam logic [5:0] ALU_MULHU = 6'd35;
    localparam logic [5:0] ALU_DIV   = 6'd36;
    localparam logic [5:0] ALU_REMU  = 6'd39;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [5:0]  ex_alucode;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        flush;
    logic        stall;
    logic        alu_start;
    logic [5:0]  alu_code;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;
    logic        alu_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic [7:0]  busy_cycles;

    int vectors;
    int miscompares;

    muldiv_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alucode(ex_alucode),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .flush(flush), .stall(stall), .alu_start(alu_start), .alu_code(alu_code),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result), .alu_done(alu_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .busy_cycles(busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic we);
        ex_valid = v; ex_alucode = code; ex_op1 = a; ex_op2 = b; ex_rd = rd; ex_reg_we = we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_ex(1'b1, ALU_MUL, 32'h11, 32'h22, 5'd3, 1'b1);
        tick(); tick(); #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0b want 0", stall); end
        vectors++; if ({alu_start, wb_valid, wb_we} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes got %b want 000", {alu_start, wb_valid, wb_we}); end
        vectors++; if ({alu_code, alu_op1, alu_op2} !== 70'd0) begin miscompares++; $display("FAIL rst_alu_bus got %h want 0", {alu_code, alu_op1, alu_op2}); end
        vectors++; if ({wb_rd, wb_data, busy_cycles} !== 45'd0) begin miscompares++; $display("FAIL rst_wb_bus got %h want 0", {wb_rd, wb_data, busy_cycles}); end
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [63:0] prod;
        set_ex(1'b1, ALU_MUL, 32'h00003141, 32'h00005926, 5'd5, 1'b1);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mul_accept_stall got %0b want 1", stall); end
        vectors++; if (alu_start !== 1'b0) begin miscompares++; $display("FAIL mul_accept_start got %0b want 0", alu_start); end
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        vectors++; if (alu_start !== 1'b1) begin miscompares++; $display("FAIL mul_start got %0b want 1", alu_start); end
        vectors++; if (alu_code !== ALU_MUL) begin miscompares++; $display("FAIL mul_code got %0d want %0d", alu_code, ALU_MUL); end
        vectors++; if ({alu_op1, alu_op2} !== {32'h00003141, 32'h00005926}) begin miscompares++; $display("FAIL mul_ops got %h want 0000314100005926", {alu_op1, alu_op2}); end
        vectors++; if (busy_cycles !== 8'd0) begin miscompares++; $display("FAIL mul_busy0 got %0d want 0", busy_cycles); end
        tick();
        vectors++; if ({alu_start, stall} !== 2'b01) begin miscompares++; $display("FAIL mul_busy2 got %b want 01", {alu_start, stall}); end
        prod = 64'h3141 * 64'h5926;
        alu_result = prod[31:0];
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        #1;
        vectors++; if ({wb_valid, wb_we, stall} !== 3'b110) begin miscompares++; $display("FAIL mul_wb_strobes got %b want 110", {wb_valid, wb_we, stall}); end
        vectors++; if (wb_data !== 32'h1126E8A6) begin miscompares++; $display("FAIL mul_wb_data got %h want 1126e8a6", wb_data); end
        vectors++; if (wb_rd !== 5'd5) begin miscompares++; $display("FAIL mul_wb_rd got %0d want 5", wb_rd); end
        vectors++; if (busy_cycles !== 8'd2) begin miscompares++; $display("FAIL mul_busy_cnt got %0d want 2", busy_cycles); end
        vectors++; if (alu_code !== ALU_MUL) begin miscompares++; $display("FAIL mul_code_held got %0d want %0d", alu_code, ALU_MUL); end
        tick();
        vectors++; if ({wb_valid, wb_data, alu_code} !== 39'd0) begin miscompares++; $display("FAIL mul_idle_clear got %h want 0", {wb_valid, wb_data, alu_code}); end
        vectors++; if (busy_cycles !== 8'd2) begin miscompares++; $display("FAIL mul_busy_hold got %0d want 2", busy_cycles); end
    endtask

    task automatic test_mulh_stale();
        logic [63:0] prod;
        alu_done = 1'b1;
        alu_result = 32'hDEADBEEF;
        set_ex(1'b1, ALU_MULH, 32'hFFFFFFFC, 32'd7, 5'd7, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        vectors++; if (alu_start !== 1'b1) begin miscompares++; $display("FAIL mulh_start got %0b want 1", alu_start); end
        tick();
        vectors++; if ({wb_valid, stall} !== 2'b01) begin miscompares++; $display("FAIL mulh_stale_masked got %b want 01", {wb_valid, stall}); end
        alu_done = 1'b0;
        tick();
        vectors++; if ({wb_valid, stall} !== 2'b01) begin miscompares++; $display("FAIL mulh_waiting got %b want 01", {wb_valid, stall}); end
        prod = 64'($signed(64'hFFFFFFFF_FFFFFFFC) * $signed(64'd7));
        alu_result = prod[63:32];
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL mulh_wb_valid got %0b want 1", wb_valid); end
        vectors++; if (wb_data !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mulh_wb_data got %h want ffffffff", wb_data); end
        vectors++; if ({wb_rd, busy_cycles} !== {5'd7, 8'd3}) begin miscompares++; $display("FAIL mulh_rd_busy got %h want 0703", {wb_rd, busy_cycles}); end
        tick();
    endtask

    task automatic test_flush_drain();
        set_ex(1'b1, ALU_DIV, 32'h27182818, 32'h00001234, 5'd12, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        tick();
        flush = 1'b1;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL drain_flush_stall got %0b want 1", stall); end
        tick();
        flush = 1'b0;
        vectors++; if ({wb_valid, stall} !== 2'b00) begin miscompares++; $display("FAIL drain_enter got %b want 00", {wb_valid, stall}); end
        vectors++; if ({alu_code, busy_cycles} !== {ALU_DIV, 8'd3}) begin miscompares++; $display("FAIL drain_held got %h want %h", {alu_code, busy_cycles}, {ALU_DIV, 8'd3}); end
        set_ex(1'b1, ALU_MUL, 32'd3, 32'd4, 5'd9, 1'b1);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL drain_mop_stall got %0b want 1", stall); end
        tick();
        vectors++; if ({alu_start, wb_valid, stall} !== 3'b001) begin miscompares++; $display("FAIL drain_wait got %b want 001", {alu_start, wb_valid, stall}); end
        alu_result = 32'h00012345;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if ({wb_valid, alu_code} !== 7'd0) begin miscompares++; $display("FAIL drain_discard got %h want 0", {wb_valid, alu_code}); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL drain_reaccept got %0b want 1", stall); end
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        vectors++; if ({alu_start, alu_code, alu_op1} !== {1'b1, ALU_MUL, 32'd3}) begin miscompares++; $display("FAIL drain_next_launch got %h want %h", {alu_start, alu_code, alu_op1}, {1'b1, ALU_MUL, 32'd3}); end
        tick();
        alu_result = 32'd12;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'd12}) begin miscompares++; $display("FAIL drain_next_wb got %h want %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd9, 32'd12}); end
        tick();
    endtask

    task automatic test_flush_corners();
        flush = 1'b1;
        set_ex(1'b1, ALU_MUL, 32'd1, 32'd2, 5'd3, 1'b1);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL idle_flush_stall got %0b want 0", stall); end
        tick();
        flush = 1'b0;
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        vectors++; if ({alu_start, alu_code, stall} !== 8'd0) begin miscompares++; $display("FAIL idle_flush_noaccept got %h want 0", {alu_start, alu_code, stall}); end
        set_ex(1'b1, ALU_MULHU, 32'd5, 32'd6, 5'd4, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        flush = 1'b1;
        alu_done = 1'b1;
        tick();
        flush = 1'b0;
        alu_done = 1'b0;
        vectors++; if ({wb_valid, alu_code, stall} !== 8'd0) begin miscompares++; $display("FAIL flush_done_idle got %h want 0", {wb_valid, alu_code, stall}); end
        tick();
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_done_nowb got %0b want 0", wb_valid); end
        set_ex(1'b1, ALU_MUL, 32'd2, 32'd3, 5'd6, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        alu_result = 32'd6;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        flush = 1'b1;
        #1;
        vectors++; if ({wb_valid, wb_data} !== {1'b1, 32'd6}) begin miscompares++; $display("FAIL wb_flush_kept got %h want 100000006", {wb_valid, wb_data}); end
        tick();
        flush = 1'b0;
        vectors++; if ({wb_valid, stall} !== 2'b00) begin miscompares++; $display("FAIL wb_flush_after got %b want 00", {wb_valid, stall}); end
    endtask

    task automatic test_divzero();
        set_ex(1'b1, ALU_DIV, 32'd10, 32'd0, 5'd8, 1'b1);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL divz_accept_stall got %0b want 1", stall); end
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
`ifdef MULDIV_DIVZERO_FAST_EN
        vectors++; if ({alu_start, wb_valid} !== 2'b01) begin miscompares++; $display("FAIL divz_fast_strobes got %b want 01", {alu_start, wb_valid}); end
        vectors++; if ({wb_data, wb_rd, busy_cycles} !== {32'hFFFFFFFF, 5'd8, 8'd0}) begin miscompares++; $display("FAIL divz_fast_wb got %h want %h", {wb_data, wb_rd, busy_cycles}, {32'hFFFFFFFF, 5'd8, 8'd0}); end
        tick();
        set_ex(1'b1, ALU_REMU, 32'd10, 32'd0, 5'd2, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        vectors++; if ({alu_start, wb_valid, wb_data} !== {2'b01, 32'd10}) begin miscompares++; $display("FAIL remz_fast_wb got %h want 10000000a", {alu_start, wb_valid, wb_data}); end
        tick();
`else
        vectors++; if ({alu_start, wb_valid, alu_op2} !== {2'b10, 32'd0}) begin miscompares++; $display("FAIL divz_launch got %h want 200000000", {alu_start, wb_valid, alu_op2}); end
        tick();
        alu_result = 32'hFFFFFFFF;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if ({wb_valid, wb_data, busy_cycles} !== {1'b1, 32'hFFFFFFFF, 8'd2}) begin miscompares++; $display("FAIL divz_alu_wb got %h want %h", {wb_valid, wb_data, busy_cycles}, {1'b1, 32'hFFFFFFFF, 8'd2}); end
        tick();
`endif
    endtask

    task automatic test_reset_midbusy();
        set_ex(1'b1, ALU_MUL, 32'd7, 32'd8, 5'd10, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        vectors++; if ({stall, alu_start, wb_valid, wb_we} !== 4'd0) begin miscompares++; $display("FAIL rstmid_strobes got %b want 0000", {stall, alu_start, wb_valid, wb_we}); end
        vectors++; if ({alu_code, alu_op1, alu_op2, busy_cycles} !== 78'd0) begin miscompares++; $display("FAIL rstmid_buses got %h want 0", {alu_code, alu_op1, alu_op2, busy_cycles}); end
        tick();
        alu_done = 1'b1;
        alu_result = 32'h0BADF00D;
        rst_n = 1'b1;
        tick();
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_nowb got %0b want 0", wb_valid); end
        set_ex(1'b1, ALU_MUL, 32'd2, 32'd5, 5'd11, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        vectors++; if ({wb_valid, stall} !== 2'b01) begin miscompares++; $display("FAIL rstmid_mask got %b want 01", {wb_valid, stall}); end
        alu_done = 1'b0;
        tick();
        alu_result = 32'd10;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if ({wb_valid, wb_data, busy_cycles} !== {1'b1, 32'd10, 8'd3}) begin miscompares++; $display("FAIL rstmid_wb got %h want %h", {wb_valid, wb_data, busy_cycles}, {1'b1, 32'd10, 8'd3}); end
        tick();
    endtask

    task automatic test_non_mop();
        set_ex(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd3, 1'b1);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL add_stall got %0b want 0", stall); end
        tick();
        vectors++; if ({alu_start, wb_valid, alu_code, stall} !== 9'd0) begin miscompares++; $display("FAIL add_ignored got %h want 0", {alu_start, wb_valid, alu_code, stall}); end
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_busy_saturate();
        set_ex(1'b1, ALU_MUL, 32'd1, 32'd1, 5'd1, 1'b1);
        tick();
        set_ex(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (299) tick();
        vectors++; if ({stall, busy_cycles} !== {1'b1, 8'd255}) begin miscompares++; $display("FAIL sat_busy got %h want 1ff", {stall, busy_cycles}); end
        alu_result = 32'd1;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        vectors++; if ({wb_valid, busy_cycles} !== {1'b1, 8'd255}) begin miscompares++; $display("FAIL sat_wb got %h want 1ff", {wb_valid, busy_cycles}); end
        tick();
        vectors++; if ({wb_valid, busy_cycles} !== {1'b0, 8'd255}) begin miscompares++; $display("FAIL sat_hold got %h want 0ff", {wb_valid, busy_cycles}); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        flush = 1'b0;
        alu_done = 1'b0;
        alu_result = 32'd0;
        test_reset();
        test_mul();
        test_mulh_stale();
        test_flush_drain();
        test_flush_corners();
        test_divzero();
        test_reset_midbusy();
        test_non_mop();
        test_busy_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
